// File: rtl/axi_rd_tracker.sv
// AXI read-channel tracker: passes AR/R straight through, caps in-flight
// bursts, timestamps each accepted AR and reports AR-to-RLAST latency.
// Also flags ID, RLAST-position and unexpected-beat errors (sticky).
module axi_rd_tracker #(
    parameter int ADDR_WIDTH      = 16,
    parameter int ID_WIDTH        = 8,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int LAT_WIDTH       = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    // upstream AR
    input  logic [ID_WIDTH-1:0]               s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]             s_axi_araddr,
    input  logic [7:0]                        s_axi_arlen,
    input  logic [2:0]                        s_axi_arsize,
    input  logic [1:0]                        s_axi_arburst,
    input  logic                              s_axi_arvalid,
    output logic                              s_axi_arready,
    // downstream AR
    output logic [ID_WIDTH-1:0]               m_axi_arid,
    output logic [ADDR_WIDTH-1:0]             m_axi_araddr,
    output logic [7:0]                        m_axi_arlen,
    output logic [2:0]                        m_axi_arsize,
    output logic [1:0]                        m_axi_arburst,
    output logic                              m_axi_arvalid,
    input  logic                              m_axi_arready,
    // downstream R
    input  logic [ID_WIDTH-1:0]               m_axi_rid,
    input  logic [DATA_WIDTH-1:0]             m_axi_rdata,
    input  logic [1:0]                        m_axi_rresp,
    input  logic                              m_axi_rlast,
    input  logic                              m_axi_rvalid,
    output logic                              m_axi_rready,
    // upstream R
    output logic [ID_WIDTH-1:0]               s_axi_rid,
    output logic [DATA_WIDTH-1:0]             s_axi_rdata,
    output logic [1:0]                        s_axi_rresp,
    output logic                              s_axi_rlast,
    output logic                              s_axi_rvalid,
    input  logic                              s_axi_rready,
    // status
    output logic [$clog2(MAX_OUTSTANDING):0]  outstanding,
    output logic                              lat_valid,
    output logic [LAT_WIDTH-1:0]              lat_value,
    output logic [ID_WIDTH-1:0]               lat_id,
    output logic                              err_id,
    output logic                              err_last,
    output logic                              err_unexp
);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    logic [LAT_WIDTH-1:0] ts_q;
    logic [ID_WIDTH-1:0]  id_mem_q  [MAX_OUTSTANDING];
    logic [7:0]           len_mem_q [MAX_OUTSTANDING];
    logic [LAT_WIDTH-1:0] ts_mem_q  [MAX_OUTSTANDING];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [7:0]           beat_q, beat_d;
    logic                 err_id_q, err_id_d;
    logic                 err_last_q, err_last_d;
    logic                 err_unexp_q, err_unexp_d;
    logic                 lat_valid_q;
    logic [LAT_WIDTH-1:0] lat_value_q;
    logic [ID_WIDTH-1:0]  lat_id_q;

    logic                 full, ar_hs, r_hs, not_empty, pop;
    logic [ID_WIDTH-1:0]  head_id;
    logic [7:0]           head_len;
    logic [LAT_WIDTH-1:0] head_ts;

    // Reset forces the gate open so upstream sees plain arready while rst is high.
    assign full      = !rst && (count_q == CNT_W'(MAX_OUTSTANDING));
    assign ar_hs     = m_axi_arvalid && m_axi_arready && !rst;
    assign r_hs      = m_axi_rvalid && s_axi_rready;
    assign not_empty = (count_q != '0);
    // Pop follows the real RLAST, even when it lands on the wrong beat.
    assign pop       = r_hs && m_axi_rlast && not_empty;

    assign head_id  = id_mem_q[rd_ptr_q];
    assign head_len = len_mem_q[rd_ptr_q];
    assign head_ts  = ts_mem_q[rd_ptr_q];

    // AR pass-through with occupancy gating; a same-cycle pop does not unblock.
    assign m_axi_arid    = s_axi_arid;
    assign m_axi_araddr  = s_axi_araddr;
    assign m_axi_arlen   = s_axi_arlen;
    assign m_axi_arsize  = s_axi_arsize;
    assign m_axi_arburst = s_axi_arburst;
    assign m_axi_arvalid = s_axi_arvalid & ~full;
    assign s_axi_arready = m_axi_arready & ~full;

    // R pass-through, no registers on the data path.
    assign m_axi_rready = s_axi_rready;
    assign s_axi_rid    = m_axi_rid;
    assign s_axi_rdata  = m_axi_rdata;
    assign s_axi_rresp  = m_axi_rresp;
    assign s_axi_rlast  = m_axi_rlast;
    assign s_axi_rvalid = m_axi_rvalid;

    assign outstanding = count_q;
    assign lat_valid   = lat_valid_q;
    assign lat_value   = lat_value_q;
    assign lat_id      = lat_id_q;
    assign err_id      = err_id_q;
    assign err_last    = err_last_q;
    assign err_unexp   = err_unexp_q;

    // Next-state for occupancy, beat position and sticky error flags.
    always_comb begin
        count_d     = count_q + CNT_W'(ar_hs) - CNT_W'(pop);
        beat_d      = beat_q;
        err_id_d    = err_id_q;
        err_last_d  = err_last_q;
        err_unexp_d = err_unexp_q;
        if (r_hs) begin
            beat_d = m_axi_rlast ? 8'd0 : beat_q + 8'd1;
            if (not_empty) begin
                if (m_axi_rid != head_id)
                    err_id_d = 1'b1;
                if (m_axi_rlast != (beat_q == head_len))
                    err_last_d = 1'b1;
            end else begin
                err_unexp_d = 1'b1;
            end
        end
    end

    // Control state: timestamp, pointers, count, beat, errors and latency report.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q        <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            beat_q      <= '0;
            err_id_q    <= 1'b0;
            err_last_q  <= 1'b0;
            err_unexp_q <= 1'b0;
            lat_valid_q <= 1'b0;
            lat_value_q <= '0;
            lat_id_q    <= '0;
        end else begin
            ts_q        <= ts_q + LAT_WIDTH'(1);
            count_q     <= count_d;
            beat_q      <= beat_d;
            err_id_q    <= err_id_d;
            err_last_q  <= err_last_d;
            err_unexp_q <= err_unexp_d;
            lat_valid_q <= pop;
            if (ar_hs)
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop) begin
                rd_ptr_q    <= rd_ptr_q + PTR_W'(1);
                lat_value_q <= ts_q - head_ts;
                lat_id_q    <= head_id;
            end
        end
    end

    // Per-entry storage of {id, len, issue timestamp}, written on AR accept.
    generate
        for (genvar gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (ar_hs && (wr_ptr_q == PTR_W'(gi))) begin
                    id_mem_q[gi]  <= s_axi_arid;
                    len_mem_q[gi] <= s_axi_arlen;
                    ts_mem_q[gi]  <= ts_q;
                end
            end
        end
    endgenerate

endmodule
